// File: rtl/alu_muldiv.sv
// ---------------------------------------------------------------------------
// alu_muldiv
//
// Iterative multiply/divide unit with architectural HI/LO registers.
//
// Operations (opselect, sampled with start while idle):
//   000 MULTU  {hi,lo} = x * y                 (unsigned)
//   001 MULT   {hi,lo} = x * y                 (two's-complement)
//   010 DIVU   lo = x / y, hi = x % y          (unsigned)
//   011 DIV    lo = x / y, hi = x % y          (signed, truncating)
//   100 MTHI   hi = x                          (single cycle)
//   101 MTLO   lo = x                          (single cycle)
//   11x        no-op, done still pulses
//
// Multiply and divide take WIDTH iterations, one bit per cycle. busy is
// high for those WIDTH cycles, and done pulses in the following cycle.
// hi/lo are written only at the edge that raises done. A zero divisor keeps
// the same latency, leaves hi/lo untouched and raises div_zero with done.
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst       synchronous active-high reset
//   start     operation request, honoured only while idle
//   opselect  operation code (see above)
//   x, y      operands: x = multiplicand/dividend/move source,
//             y = multiplier/divisor
//   busy      high while an iterative operation runs
//   done      one-cycle completion pulse
//   hi, lo    architectural HI and LO registers
//   div_zero  pulses together with done when the divisor was zero
// ---------------------------------------------------------------------------
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opselect,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = $clog2(WIDTH);

  logic [1:0]         state_reg;
  logic [CW-1:0]      cnt_reg;
  // Shared working register. Multiply: upper half accumulates the partial
  // product, lower half holds the multiplier and shifts out one bit per
  // cycle. Divide: upper half is the partial remainder, lower half starts
  // as the dividend and fills up with quotient bits from the right.
  logic [2*WIDTH-1:0] acc_reg;
  // Multiplicand (multiply) or divisor (divide), as a magnitude.
  logic [WIDTH-1:0]   m_reg;
  logic               is_div_reg;
  logic               neg_q_reg;   // negate product / quotient at the end
  logic               neg_r_reg;   // negate remainder at the end
  logic               dz_reg;      // current divide has a zero divisor
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  // -------------------------------------------------------------------------
  // Operand conditioning at acceptance: signed codes work on magnitudes.
  // The magnitude of the most-negative value is its own bit pattern read as
  // unsigned, which is exactly what the unsigned datapath needs.
  // -------------------------------------------------------------------------
  logic             signed_op;
  logic             x_neg;
  logic             y_neg;
  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;

  assign signed_op = opselect[0];
  assign x_neg     = signed_op & x[WIDTH-1];
  assign y_neg     = signed_op & y[WIDTH-1];
  assign x_mag     = x_neg ? -x : x;
  assign y_mag     = y_neg ? -y : y;

  // -------------------------------------------------------------------------
  // One shift-add multiply step: conditionally add the multiplicand into the
  // upper half (keeping the carry), then shift the whole register right.
  // -------------------------------------------------------------------------
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                    (acc_reg[0] ? {1'b0, m_reg} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

  // -------------------------------------------------------------------------
  // One restoring divide step: shift the next dividend bit into the partial
  // remainder, try subtracting the divisor, keep the difference only if it
  // did not go negative. The shifted remainder is below 2*divisor, so WIDTH+1
  // bits hold it without overflow.
  // -------------------------------------------------------------------------
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
  assign div_ge    = (div_shift >= {1'b0, m_reg});
  assign div_diff  = div_shift - {1'b0, m_reg};
  assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc_reg[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] acc_step;
  assign acc_step = is_div_reg ? div_next : mul_next;

  // -------------------------------------------------------------------------
  // Sign fix-up applied to the value produced by the final iteration, so the
  // architectural registers only ever see finished results.
  // -------------------------------------------------------------------------
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quo_raw;
  logic [WIDTH-1:0]   rem_raw;
  logic [WIDTH-1:0]   quo_res;
  logic [WIDTH-1:0]   rem_res;
  logic [WIDTH-1:0]   hi_next;
  logic [WIDTH-1:0]   lo_next;

  assign mul_res = neg_q_reg ? -acc_step : acc_step;
  assign quo_raw = acc_step[WIDTH-1:0];
  assign rem_raw = acc_step[2*WIDTH-1:WIDTH];
  assign quo_res = neg_q_reg ? -quo_raw : quo_raw;
  assign rem_res = neg_r_reg ? -rem_raw : rem_raw;
  assign hi_next = is_div_reg ? rem_res : mul_res[2*WIDTH-1:WIDTH];
  assign lo_next = is_div_reg ? quo_res : mul_res[WIDTH-1:0];

  logic last_iter;
  assign last_iter = (cnt_reg == CW'(WIDTH - 1));

  // -------------------------------------------------------------------------
  // Control and state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      m_reg      <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      dz_reg     <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            if (!opselect[2]) begin
              // Multiply or divide: latch everything the iteration needs so
              // the inputs are free to change afterwards.
              state_reg  <= S_RUN;
              cnt_reg    <= '0;
              is_div_reg <= opselect[1];
              neg_q_reg  <= x_neg ^ y_neg;
              neg_r_reg  <= x_neg;
              dz_reg     <= opselect[1] & (y == '0);
              if (opselect[1]) begin
                acc_reg <= {{WIDTH{1'b0}}, x_mag};
                m_reg   <= y_mag;
              end else begin
                acc_reg <= {{WIDTH{1'b0}}, y_mag};
                m_reg   <= x_mag;
              end
            end else begin
              // Moves complete at the accepting edge; no-ops only pulse done.
              state_reg <= S_DONE;
              dz_reg    <= 1'b0;
              case (opselect[1:0])
                2'b00:   hi_reg <= x;
                2'b01:   lo_reg <= x;
                default: ;
              endcase
            end
          end
        end

        S_RUN: begin
          acc_reg <= acc_step;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_iter) begin
            state_reg <= S_DONE;
            if (!dz_reg) begin
              hi_reg <= hi_next;
              lo_reg <= lo_next;
            end
          end
        end

        S_DONE: begin
          state_reg <= S_IDLE;
          dz_reg    <= 1'b0;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state_reg == S_RUN);
  assign done     = (state_reg == S_DONE);
  assign div_zero = (state_reg == S_DONE) & dz_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   opselect;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .opselect (opselect),
    .x        (x),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] xv;
    logic [W-1:0] yv;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t exp_q[$];

  int check_cnt = 0;
  int pass_cnt  = 0;

  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    check_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural meaning.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] xv,
                                 input logic [W-1:0] yv);
    exp_t         e;
    logic [63:0]  p;
    longint       a;
    longint       b;
    longint       q;
    longint       r;
    e.op = op; e.xv = xv; e.yv = yv;
    e.hi = model_hi; e.lo = model_lo; e.dz = 1'b0;
    a = longint'($signed(xv));
    b = longint'($signed(yv));
    case (op)
      3'd0: begin p = {32'd0, xv} * {32'd0, yv}; e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd1: begin p = a * b; e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd2: begin
        if (yv == 0) e.dz = 1'b1;
        else begin e.lo = xv / yv; e.hi = xv % yv; end
      end
      3'd3: begin
        if (yv == 0) e.dz = 1'b1;
        else begin
          q = a / b; r = a % b;
          p = q; e.lo = p[31:0];
          p = r; e.hi = p[31:0];
        end
      end
      3'd4: e.hi = xv;
      3'd5: e.lo = xv;
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT signals completion.
  always @(negedge clk) begin
    if (!rst) begin
      if (div_zero && !done) begin
        check_cnt++;
        $display("FAIL div_zero_without_done: got 1, expected 0");
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check_cnt++;
          $display("FAIL unexpected_done: got done=1, expected no completion");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("txn op=%0d x=%08h y=%08h -> hi=%08h lo=%08h dz=%0b (model hi=%08h lo=%08h dz=%0b)",
                   e.op, e.xv, e.yv, hi, lo, div_zero, e.hi, e.lo, e.dz);
          check("hi", 64'(hi), 64'(e.hi));
          check("lo", 64'(lo), 64'(e.lo));
          check("div_zero", 64'(div_zero), 64'(e.dz));
        end
      end
    end
  end

  // Issue one operation and verify its busy/done timing.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] xv, input logic [W-1:0] yv);
    exp_t e;
    int   n;
    int   busy_n;
    bit   seen;
    bit   is_md;
    @(negedge clk);
    check("quiet_before_start", {62'd0, done, div_zero}, 64'd0);
    e = model(op, xv, yv);
    model_hi = e.hi;
    model_lo = e.lo;
    exp_q.push_back(e);
    is_md = (op[2] == 1'b0);
    start = 1'b1; opselect = op; x = xv; y = yv;
    @(posedge clk);
    #1;
    start = 1'b0;
    opselect = 3'($urandom); x = $urandom; y = $urandom;
    n = 0; busy_n = 0; seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (busy) busy_n++;
      if (done) seen = 1;
    end
    check("latency", 64'(n), is_md ? 64'(W + 1) : 64'd1);
    check("busy_cycles", 64'(busy_n), is_md ? 64'(W) : 64'd0);
  endtask

  function automatic logic [W-1:0] rand_x();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [W-1:0] rand_y();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return $urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; opselect = 3'd0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
    rst = 1'b0;

    // Directed cases
    do_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(3'd1, 32'hFFFF_FFFD, 32'd7);
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2);
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(3'd4, 32'h1234_5678, 32'd0);
    do_op(3'd2, 32'd100, 32'd0);
    do_op(3'd6, 32'hDEAD_BEEF, 32'd1);
    do_op(3'd5, 32'hCAFE_F00D, 32'd0);
    do_op(3'd3, 32'd7, 32'hFFFF_FFFE);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd3);
    do_op(3'd7, 32'h0, 32'h0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), rand_x(), rand_y());
    end

    // Reset has priority over start in the same cycle.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; opselect = 3'd5; x = 32'hABCD_0123;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    model_hi = '0; model_lo = '0;
    check("rst_priority_lo", 64'(lo), 64'd0);
    check("rst_priority_done", 64'(done), 64'd0);

    do_op(3'd4, 32'h5555_AAAA, 32'd0);
    do_op(3'd5, 32'h0F0F_F0F0, 32'd0);

    // MULT accepted, a second start at cycle 5 ignored, reset at cycle 10.
    @(negedge clk);
    start = 1'b1; opselect = 3'd1; x = 32'd5; y = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; opselect = 3'd4; x = 32'hDEAD_0000;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("ignored_start_busy", 64'(busy), 64'd1);
    check("ignored_start_hi", 64'(hi), 64'(model_hi));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_hi = '0; model_lo = '0;
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_busy_done", {62'd0, busy, done}, 64'd0);
    do_op(3'd0, 32'd12345, 32'd678);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000);

    repeat (40) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
